// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: state encodings, control-word layout,
// select/ALU opcode constants, ARM condition codes, and the per-state control-word
// builder used by the FSM's registered output.
package cu_pkg;

    typedef enum logic [3:0] {
        S_RESET       = 4'd0,
        S_FETCH_ADDR  = 4'd1,
        S_FETCH_READ  = 4'd2,
        S_FETCH_LATCH = 4'd3,
        S_PC_INC      = 4'd4,
        S_DECODE      = 4'd5,
        S_DP_EXEC     = 4'd6,
        S_LDST_ADDR   = 4'd7,
        S_LDST_MEM    = 4'd8,
        S_LDST_WB     = 4'd9,
        S_BRANCH      = 4'd10,
        S_FAULT       = 4'd11
    } cu_state_e;

    typedef enum logic [3:0] {
        CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
        CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
        CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
        CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
    } cond_e;

    // Single-bit control positions
    localparam int CW_MFA    = 31;
    localparam int CW_RW_RAM = 30;
    localparam int CW_SALU   = 29;
    localparam int CW_RF_RW  = 28;
    localparam int CW_SSAB   = 27;
    localparam int CW_SSOP   = 26;
    localparam int CW_SMA    = 25;
    localparam int CW_STA    = 24;
    localparam int CW_MAR_EN = 23;
    localparam int CW_SR_EN  = 22;
    localparam int CW_MDR_EN = 21;
    localparam int CW_IR_EN  = 20;
    localparam int CW_SHT_EN = 19;
    localparam int CW_ISE_EN = 18;
    localparam int CW_SGN_EN = 17;
    localparam int CW_CLR    = 16;

    // 2-bit select field LSB positions, then the 4-bit ALU opcode
    localparam int DSS_LSB   = 14;
    localparam int WRA_LSB   = 12;
    localparam int SRA_LSB   = 10;
    localparam int SRB_LSB   = 8;
    localparam int SISE_LSB  = 6;
    localparam int SALUB_LSB = 4;
    localparam int ALUA_LSB  = 0;

    localparam logic [1:0] DSS_ALU     = 2'd0;
    localparam logic [1:0] DSS_MDR     = 2'd1;
    localparam logic [1:0] WRA_RD      = 2'd0;
    localparam logic [1:0] WRA_PC      = 2'd1;
    localparam logic [1:0] WRA_LR      = 2'd2;
    localparam logic [1:0] WRA_PC_LR   = 2'd3;
    localparam logic [1:0] SRA_RN      = 2'd0;
    localparam logic [1:0] SRA_PC      = 2'd1;
    localparam logic [1:0] SRB_RM      = 2'd0;
    localparam logic [1:0] SRB_RD      = 2'd1;
    localparam logic [1:0] SISE_ROT8   = 2'd0;
    localparam logic [1:0] SISE_IMM12  = 2'd1;
    localparam logic [1:0] SISE_IMM24  = 2'd2;
    localparam logic [1:0] SALUB_REG   = 2'd0;
    localparam logic [1:0] SALUB_IMM   = 2'd1;
    localparam logic [1:0] SALUB_FOUR  = 2'd2;

    localparam logic [3:0] ALU_SUB = 4'h2;
    localparam logic [3:0] ALU_ADD = 4'h4;

    // Quiescent word: active-low enables and CLR parked at 1, RAM direction on read
    localparam logic [31:0] CW_IDLE = (32'd1 << CW_RW_RAM) | (32'd1 << CW_MAR_EN) |
                                      (32'd1 << CW_SR_EN)  | (32'd1 << CW_MDR_EN) |
                                      (32'd1 << CW_IR_EN)  | (32'd1 << CW_CLR);
    localparam logic [31:0] CW_RESET = CW_IDLE & ~(32'd1 << CW_CLR);

    // Control word presented while the FSM sits in state s (ir supplies instruction fields)
    function automatic logic [31:0] cw_word(input cu_state_e s, input logic [31:0] ir);
        logic [31:0] w;
        w = CW_IDLE;
        case (s)
            S_RESET: w[CW_CLR] = 1'b0;
            S_FETCH_ADDR: begin
                w[CW_MAR_EN]       = 1'b0;
                w[CW_SMA]          = 1'b1;
                w[SRA_LSB +: 2]    = SRA_PC;
            end
            S_FETCH_READ: begin
                w[CW_MFA]          = 1'b1;
                w[CW_RW_RAM]       = 1'b1;
                w[CW_MDR_EN]       = 1'b0;
            end
            S_FETCH_LATCH: w[CW_IR_EN] = 1'b0;
            S_PC_INC: begin
                w[CW_RF_RW]        = 1'b1;
                w[WRA_LSB +: 2]    = WRA_PC;
                w[SRA_LSB +: 2]    = SRA_PC;
                w[SALUB_LSB +: 2]  = SALUB_FOUR;
                w[ALUA_LSB +: 4]   = ALU_ADD;
                w[DSS_LSB +: 2]    = DSS_ALU;
            end
            S_DP_EXEC: begin
                w[CW_RF_RW]        = 1'b1;
                w[CW_SHT_EN]       = 1'b1;
                w[CW_SR_EN]        = ~ir[20];
                w[WRA_LSB +: 2]    = WRA_RD;
                w[SRA_LSB +: 2]    = SRA_RN;
                w[SRB_LSB +: 2]    = SRB_RM;
                w[SISE_LSB +: 2]   = SISE_ROT8;
                w[SALUB_LSB +: 2]  = ir[25] ? SALUB_IMM : SALUB_REG;
                w[ALUA_LSB +: 4]   = ir[24:21];
                w[DSS_LSB +: 2]    = DSS_ALU;
            end
            S_LDST_ADDR: begin
                // Base +/- imm12 (U bit picks the direction) goes through the ALU into MAR
                w[CW_MAR_EN]       = 1'b0;
                w[CW_ISE_EN]       = 1'b1;
                w[SRA_LSB +: 2]    = SRA_RN;
                w[SISE_LSB +: 2]   = SISE_IMM12;
                w[SALUB_LSB +: 2]  = SALUB_IMM;
                w[ALUA_LSB +: 4]   = ir[23] ? ALU_ADD : ALU_SUB;
            end
            S_LDST_MEM: begin
                // Loads capture RAM data in MDR; stores drive Rd onto the store path
                w[CW_MFA]          = 1'b1;
                w[CW_RW_RAM]       = ir[20];
                w[CW_MDR_EN]       = ~ir[20];
                w[CW_STA]          = ~ir[20];
                w[SRB_LSB +: 2]    = SRB_RD;
            end
            S_LDST_WB: begin
                w[CW_RF_RW]        = ir[20];
                w[WRA_LSB +: 2]    = WRA_RD;
                w[DSS_LSB +: 2]    = DSS_MDR;
            end
            S_BRANCH: begin
                w[CW_RF_RW]        = 1'b1;
                w[CW_ISE_EN]       = 1'b1;
                w[CW_SGN_EN]       = 1'b1;
                w[CW_SHT_EN]       = 1'b1;
                w[WRA_LSB +: 2]    = ir[24] ? WRA_PC_LR : WRA_PC;
                w[SRA_LSB +: 2]    = SRA_PC;
                w[SISE_LSB +: 2]   = SISE_IMM24;
                w[SALUB_LSB +: 2]  = SALUB_IMM;
                w[ALUA_LSB +: 4]   = ALU_ADD;
                w[DSS_LSB +: 2]    = DSS_ALU;
            end
            default: w = CW_IDLE;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluator: pass=1 when cond is satisfied by flags {N,Z,C,V}.
// Latency: purely combinational.
// Backpressure: none.
module cond_check
    import cu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;
    assign n = flags[3];
    assign z = flags[2];
    assign c = flags[1];
    assign v = flags[0];

    // Standard ARM condition table; NV never passes
    always_comb begin
        pass = 1'b0;
        case (cond)
            CC_EQ: pass = z;
            CC_NE: pass = ~z;
            CC_CS: pass = c;
            CC_CC: pass = ~c;
            CC_MI: pass = n;
            CC_PL: pass = ~n;
            CC_VS: pass = v;
            CC_VC: pass = ~v;
            CC_HI: pass = c & ~z;
            CC_LS: pass = ~c | z;
            CC_GE: pass = (n == v);
            CC_LT: pass = (n != v);
            CC_GT: pass = ~z & (n == v);
            CC_LE: pass = z | (n != v);
            CC_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle ARM-subset sequencer driving a registered Moore control word to the data path.
// Latency: CW/State/Fault update on the same edge as the state; memory waits up to MFC_TIMEOUT cycles.
// Backpressure: holds in FETCH_READ/LDST_MEM until MFC, parks in FAULT on timeout until reset.
module control_unit
    import cu_pkg::*;
#(
    parameter int MFC_TIMEOUT = 15,
    parameter int CW_W        = 32   // layout is fixed at 32 bits
) (
    input  logic            CLK,
    input  logic            CLR_N,
    input  logic [31:0]     IR_Out,
    input  logic            MFC,
    input  logic [3:0]      Flags,
    output logic [CW_W-1:0] CW,
    output logic [3:0]      State,
    output logic            Fault
);

    localparam logic [3:0] TMO_LAST = 4'(MFC_TIMEOUT - 1);

    cu_state_e   state_q, state_nxt;
    logic [3:0]  wait_cnt;
    logic [31:0] cw_q;
    logic        cond_pass;
    logic        in_wait;

    cond_check u_cond_check (
        .cond  (IR_Out[31:28]),
        .flags (Flags),
        .pass  (cond_pass)
    );

    assign in_wait = (state_q == S_FETCH_READ) || (state_q == S_LDST_MEM);
    assign CW      = cw_q;
    assign State   = state_q;

    // Next-state selection; MFC wins over the timeout on the final wait cycle
    always_comb begin
        state_nxt = S_RESET;
        case (state_q)
            S_RESET:       state_nxt = S_FETCH_ADDR;
            S_FETCH_ADDR:  state_nxt = S_FETCH_READ;
            S_FETCH_READ: begin
                if (MFC)                        state_nxt = S_FETCH_LATCH;
                else if (wait_cnt == TMO_LAST)  state_nxt = S_FAULT;
                else                            state_nxt = S_FETCH_READ;
            end
            S_FETCH_LATCH: state_nxt = S_PC_INC;
            S_PC_INC:      state_nxt = S_DECODE;
            S_DECODE: begin
                if (!cond_pass) begin
                    state_nxt = S_FETCH_ADDR;
                end else begin
                    case (IR_Out[27:25])
                        3'b000, 3'b001: state_nxt = S_DP_EXEC;
                        3'b010, 3'b011: state_nxt = S_LDST_ADDR;
                        3'b101:         state_nxt = S_BRANCH;
                        default:        state_nxt = S_FETCH_ADDR;
                    endcase
                end
            end
            S_DP_EXEC:     state_nxt = S_FETCH_ADDR;
            S_LDST_ADDR:   state_nxt = S_LDST_MEM;
            S_LDST_MEM: begin
                if (MFC)                        state_nxt = S_LDST_WB;
                else if (wait_cnt == TMO_LAST)  state_nxt = S_FAULT;
                else                            state_nxt = S_LDST_MEM;
            end
            S_LDST_WB:     state_nxt = S_FETCH_ADDR;
            S_BRANCH:      state_nxt = S_FETCH_ADDR;
            S_FAULT:       state_nxt = S_FAULT;
            default:       state_nxt = S_RESET;
        endcase
    end

    // State, wait counter, sticky fault and the control word all register together
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q  <= S_RESET;
            wait_cnt <= '0;
            Fault    <= 1'b0;
            cw_q     <= CW_RESET;
        end else begin
            state_q  <= state_nxt;
            wait_cnt <= in_wait ? wait_cnt + 4'd1 : 4'd0;
            Fault    <= (state_nxt == S_FAULT);
            cw_q     <= cw_word(state_nxt, IR_Out);
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: fetch/decode/execute paths,
// condition evaluation, memory-wait timeout boundary and asynchronous reset.
module tb_control_unit;
    import cu_pkg::*;

    logic        CLK = 1'b0;
    logic        CLR_N;
    logic [31:0] IR_Out;
    logic        MFC;
    logic [3:0]  Flags;
    logic [31:0] CW;
    logic [3:0]  State;
    logic        Fault;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [31:0] RESET_WORD = 32'h40F0_0000;
    localparam logic [31:0] IDLE_WORD  = 32'h40F1_0000;

    control_unit #(.MFC_TIMEOUT(15), .CW_W(32)) dut (
        .CLK    (CLK),
        .CLR_N  (CLR_N),
        .IR_Out (IR_Out),
        .MFC    (MFC),
        .Flags  (Flags),
        .CW     (CW),
        .State  (State),
        .Fault  (Fault)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, State}, {28'd0, exp});
    endtask

    task automatic chk_bit(input string tag, input int pos, input logic exp);
        chk(tag, {31'd0, CW[pos]}, {31'd0, exp});
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // From FETCH_ADDR with MFC high, four edges reach DECODE
    task automatic fetch_to_decode(input logic [31:0] ir, input logic [3:0] fl);
        IR_Out = ir;
        Flags  = fl;
        MFC    = 1'b1;
        tick; tick; tick; tick;
        chk_state("at_decode", 4'd5);
    endtask

    task automatic back_to_fetch;
        for (int i = 0; i < 8 && State != 4'd1; i++) tick;
        chk_state("return_to_fetch", 4'd1);
    endtask

    logic [31:0] t_ir  [9];
    logic [3:0]  t_fl  [9];
    logic [3:0]  t_nxt [9];

    initial begin
        t_ir[0] = 32'h0281_1001; t_fl[0] = 4'b0000; t_nxt[0] = 4'd1;   // EQ, Z=0
        t_ir[1] = 32'h0281_1001; t_fl[1] = 4'b0100; t_nxt[1] = 4'd6;   // EQ, Z=1
        t_ir[2] = 32'hF281_1001; t_fl[2] = 4'b1111; t_nxt[2] = 4'd1;   // NV
        t_ir[3] = 32'hA281_1001; t_fl[3] = 4'b1001; t_nxt[3] = 4'd6;   // GE, N=V
        t_ir[4] = 32'hB281_1001; t_fl[4] = 4'b1001; t_nxt[4] = 4'd1;   // LT, N=V
        t_ir[5] = 32'h8281_1001; t_fl[5] = 4'b0010; t_nxt[5] = 4'd6;   // HI, C=1 Z=0
        t_ir[6] = 32'h9281_1001; t_fl[6] = 4'b0010; t_nxt[6] = 4'd1;   // LS, C=1 Z=0
        t_ir[7] = 32'hC281_1001; t_fl[7] = 4'b0100; t_nxt[7] = 4'd1;   // GT, Z=1
        t_ir[8] = 32'hE800_0000; t_fl[8] = 4'b0000; t_nxt[8] = 4'd1;   // class 100 -> NOP

        CLR_N  = 1'b0;
        IR_Out = 32'h0;
        MFC    = 1'b0;
        Flags  = 4'h0;
        #12;
        chk_state("reset_state", 4'd0);
        chk("reset_cw", CW, RESET_WORD);
        chk("reset_fault", {31'd0, Fault}, 32'd0);

        // Data-processing ADD, MFC arrives one cycle after MFA rises
        CLR_N  = 1'b1;
        IR_Out = 32'hE281_1001;
        tick; chk_state("dp_s1", 4'd1);
        chk_bit("fa_mar_en", CW_MAR_EN, 1'b0);
        chk_bit("fa_clr", CW_CLR, 1'b1);
        tick; chk_state("dp_s2", 4'd2);
        chk_bit("fr_mfa", CW_MFA, 1'b1);
        chk_bit("fr_rw", CW_RW_RAM, 1'b1);
        chk_bit("fr_mdr_en", CW_MDR_EN, 1'b0);
        tick; chk_state("dp_s2_wait", 4'd2);
        MFC = 1'b1;
        tick; chk_state("dp_s3", 4'd3);
        chk_bit("fl_ir_en", CW_IR_EN, 1'b0);
        tick; chk_state("dp_s4", 4'd4);
        chk_bit("pc_rf_rw", CW_RF_RW, 1'b1);
        chk("pc_wra", {30'd0, CW[WRA_LSB +: 2]}, {30'd0, WRA_PC});
        tick; chk_state("dp_s5", 4'd5);
        chk_bit("dec_rf_rw", CW_RF_RW, 1'b0);
        tick; chk_state("dp_s6", 4'd6);
        chk("dp_alua", {28'd0, CW[ALUA_LSB +: 4]}, 32'h4);
        chk_bit("dp_sr_en", CW_SR_EN, 1'b1);
        chk_bit("dp_rf_rw", CW_RF_RW, 1'b1);
        tick; chk_state("dp_s1_again", 4'd1);

        // Condition table and dispatch of unsupported class
        for (int i = 0; i < 9; i++) begin
            fetch_to_decode(t_ir[i], t_fl[i]);
            tick;
            chk_state("cond_next", t_nxt[i]);
            if (t_nxt[i] == 4'd1) begin
                chk_bit("skip_rf_rw", CW_RF_RW, 1'b0);
                chk_bit("skip_sr_en", CW_SR_EN, 1'b1);
            end else begin
                back_to_fetch;
            end
        end

        // LDR with one extra wait cycle in LDST_MEM
        fetch_to_decode(32'hE591_2000, 4'h0);
        MFC = 1'b0;
        tick; chk_state("ldr_s7", 4'd7);
        chk_bit("ldr_mar_en", CW_MAR_EN, 1'b0);
        tick; chk_state("ldr_s8", 4'd8);
        chk_bit("ldr_mfa", CW_MFA, 1'b1);
        chk_bit("ldr_rw", CW_RW_RAM, 1'b1);
        tick; chk_state("ldr_s8_wait", 4'd8);
        MFC = 1'b1;
        tick; chk_state("ldr_s9", 4'd9);
        chk_bit("ldr_wb_rf_rw", CW_RF_RW, 1'b1);
        chk("ldr_wb_dss", {30'd0, CW[DSS_LSB +: 2]}, {30'd0, DSS_MDR});
        tick; chk_state("ldr_s1", 4'd1);

        // STR: write direction, no register write-back
        fetch_to_decode(32'hE581_2000, 4'h0);
        tick; chk_state("str_s7", 4'd7);
        tick; chk_state("str_s8", 4'd8);
        chk_bit("str_mfa", CW_MFA, 1'b1);
        chk_bit("str_rw", CW_RW_RAM, 1'b0);
        tick; chk_state("str_s9", 4'd9);
        chk_bit("str_wb_rf_rw", CW_RF_RW, 1'b0);
        tick; chk_state("str_s1", 4'd1);

        // BL writes PC and link; B writes PC only
        fetch_to_decode(32'hEB00_0001, 4'h0);
        tick; chk_state("bl_s10", 4'd10);
        chk_bit("bl_rf_rw", CW_RF_RW, 1'b1);
        chk("bl_wra", {30'd0, CW[WRA_LSB +: 2]}, {30'd0, WRA_PC_LR});
        tick; chk_state("bl_s1", 4'd1);
        fetch_to_decode(32'hEA00_0001, 4'h0);
        tick; chk_state("b_s10", 4'd10);
        chk("b_wra", {30'd0, CW[WRA_LSB +: 2]}, {30'd0, WRA_PC});
        tick; chk_state("b_s1", 4'd1);

        // MFC on the final allowed wait cycle still completes the access
        MFC = 1'b0;
        tick; chk_state("edge_s2", 4'd2);
        repeat (14) tick;
        chk_state("edge_still_s2", 4'd2);
        MFC = 1'b1;
        tick; chk_state("edge_s3", 4'd3);
        chk("edge_fault", {31'd0, Fault}, 32'd0);
        back_to_fetch;

        // Timeout: 15 waiting cycles then FAULT, which persists
        MFC = 1'b0;
        tick; chk_state("tmo_s2", 4'd2);
        repeat (14) tick;
        chk_state("tmo_s2_last", 4'd2);
        tick; chk_state("tmo_s11", 4'd11);
        chk("tmo_fault", {31'd0, Fault}, 32'd1);
        chk("tmo_cw", CW, IDLE_WORD);
        MFC = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            chk_state("fault_hold_state", 4'd11);
            chk("fault_hold_flag", {31'd0, Fault}, 32'd1);
            chk_bit("fault_hold_mfa", CW_MFA, 1'b0);
        end

        // Asynchronous reset clears FAULT immediately
        #2; CLR_N = 1'b0; #1;
        chk_state("rst_fault_state", 4'd0);
        chk("rst_fault_flag", {31'd0, Fault}, 32'd0);
        chk("rst_fault_cw", CW, RESET_WORD);
        CLR_N = 1'b1;
        tick; chk_state("rst_fault_s1", 4'd1);

        // Asynchronous reset in the middle of a fetch wait
        MFC = 1'b0;
        tick; chk_state("mid_s2", 4'd2);
        repeat (5) tick;
        chk_state("mid_s2_wait", 4'd2);
        #2; CLR_N = 1'b0; #1;
        chk_state("mid_rst_state", 4'd0);
        chk("mid_rst_cw", CW, RESET_WORD);
        chk("mid_rst_fault", {31'd0, Fault}, 32'd0);
        tick; chk_state("mid_rst_held", 4'd0);
        CLR_N = 1'b1;
        tick; chk_state("mid_restart_s1", 4'd1);
        tick; chk_state("mid_restart_s2", 4'd2);
        repeat (14) tick;
        chk_state("mid_restart_full_wait", 4'd2);
        MFC = 1'b1;
        tick; chk_state("mid_restart_s3", 4'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter MFC_TIMEOUT, default 15: maximum cycles spent waiting for MFC before a fault is declared.
REQ-002 Parameter CW_W, default 32: control-word width; fixed at 32 in this design.
REQ-003 Timing: one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  rising-edge system clock, shared with data_path.
REQ-005 CLR_N  input  1  asynchronous active-low reset.
REQ-006 IR_Out  input  32  current instruction from the data_path instruction register.
REQ-007 MFC  input  1  memory-function-complete from RAM.
REQ-008 Flags  input  4  status register {N,Z,C,V}, bit3 = N.
REQ-009 CW  output  32  control word to data_path, in this order:
- [31:16] single-bit controls: MFA, RW_RAM, SALU, RF_RW, SSAB, SSOP, SMA, STA, MAR_EN, SR_EN, MDR_EN, IR_EN, SHT_EN, ISE_EN, SGN_EN, CLR.
- [15:4] 2-bit selects: DSS, WRA, SRA, SRB, SISE, SALUB.
- [3:0] ALUA.
REQ-010 State  output  4  current FSM state encoding, for debug.
REQ-011 Fault  output  1  sticky memory-timeout indicator.

Function
REQ-012 FSM states and encodings:
- RESET=0, FETCH_ADDR=1, FETCH_READ=2, FETCH_LATCH=3, PC_INC=4, DECODE=5.
- DP_EXEC=6, LDST_ADDR=7, LDST_MEM=8, LDST_WB=9, BRANCH=10, FAULT=11.
- Unused encodings SHALL return to RESET on the next edge.
REQ-013 CW SHALL be a registered Moore output, a pure function of the state register, so each control word holds for exactly the cycles spent in its state.
REQ-014 Control polarity:
- MFA=1 requests a memory access.
- RW_RAM=1 selects read, 0 selects write.
- MAR_EN, SR_EN, MDR_EN, IR_EN and CLR are active-low; inactive value is 1.
REQ-015 RESET: CLR=0, all enables inactive, MFA=0; advances to FETCH_ADDR unconditionally after one cycle.
REQ-016 FETCH_ADDR: MAR_EN=0 with the PC routed to MAR; advances after one cycle.
REQ-017 FETCH_READ: MFA=1, RW_RAM=1, MDR_EN=0.
- Holds while MFC=0.
- Advances to FETCH_LATCH on the first edge where MFC=1.
REQ-018 FETCH_LATCH: IR_EN=0; PC_INC: RF_RW write of PC+4 into R15; each lasts one cycle.
REQ-019 DECODE SHALL evaluate IR_Out[31:28] against Flags using the ARM condition table.
- Code 1110 always passes.
- Code 1111 always fails.
- On fail, the next state is FETCH_ADDR with no register writes.
REQ-020 DECODE dispatch on IR_Out[27:25]:
- 000/001 go to DP_EXEC.
- 010/011 go to LDST_ADDR.
- 101 goes to BRANCH.
- Any other value goes to FETCH_ADDR, executed as a NOP.
REQ-021 DP_EXEC: ALUA=IR_Out[24:21] with a register-file write; SR_EN=0 only when IR_Out[20]=1; returns to FETCH_ADDR.
REQ-022 LDST_ADDR: MAR_EN=0 with the ALU-computed address.
REQ-023 LDST_MEM: MFA=1, RW_RAM=IR_Out[20]; waits for MFC as in FETCH_READ.
REQ-024 LDST_WB: register write of the MDR only when IR_Out[20]=1; returns to FETCH_ADDR.
REQ-025 BRANCH: writes PC+SignExtend(IR_Out[23:0])<<2 into R15, plus an R14 link write when IR_Out[24]=1; returns to FETCH_ADDR.
REQ-026 Wait counter:
- A 4-bit counter SHALL clear on entry to FETCH_READ or LDST_MEM and increment each waiting cycle.
- On reaching MFC_TIMEOUT with MFC still 0, the FSM enters FAULT.
- MFC=1 in the same cycle the limit is reached takes priority and the access completes.
REQ-027 FAULT SHALL drive MFA=0 with all enables inactive, set Fault=1, and remain there until reset.
REQ-028 Once the access has completed, MFC remaining high after leaving a wait state SHALL be ignored.

Reset
REQ-029 CLR_N=0 SHALL immediately, asynchronously, force the state to RESET, the wait counter to 0, Fault to 0, and CW to the RESET word, including in the middle of a memory wait.
REQ-030 After CLR_N deasserts, the first rising edge SHALL move the FSM to FETCH_ADDR.

Structure
REQ-031 A shared package cu_pkg SHALL hold:
- state encodings;
- CW bit and field positions;
- select and ALU opcode constants;
- the condition-code enumeration.
REQ-032 Condition evaluation SHALL be one combinational sub-module, cond_check (inputs cond[3:0] and flags[3:0], output pass), instantiated once.

Verification
REQ-033 Reset, then IR=0xE2811001 with MFC=1 one cycle after MFA rises:
- State sequence 1,2,3,4,5,6,1.
- DP_EXEC shows ALUA=0100, with SR_EN=1 because S=0.
REQ-034 IR=0x02811001 (EQ) with Flags=0000: DECODE goes to state 1; RF_RW write and SR_EN are never asserted.
REQ-035 IR=0xE5912000 (LDR): sequence 5,7,8,9,1; LDST_MEM shows MFA=1 and RW_RAM=1; LDST_WB performs the register write.
REQ-036 MFC held 0 in FETCH_READ: after 15 wait cycles State=11, Fault=1, MFA=0, and these persist for 20 further cycles.
REQ-037 CLR_N pulsed low mid-FETCH_READ: State=0 and CW=RESET word immediately; Fault=0; fetch restarts cleanly at state 1.
